spi_bus_arbiter: RTL
====================

Name: spi_bus_arbiter

Overview:
- Two-master Wishbone arbiter in front of the single SPI SRAM controller (Wishbone slave: 24-bit address, 8-bit data).
- Shares the one SPI port between the compute engine (m0) and the host/config loader (m1).
- Round-robin grant, locked for the whole `cyc` of the owner.
- Watchdog aborts a slave access that never acks and returns `err` to the owner.

Parameters:
- TIMEOUT, 255, max cycles `s_stb_o` may stay high without `s_ack_i`; 0 disables the watchdog.
- TW, 8, watchdog counter width; must satisfy TIMEOUT < 2**TW.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- mN_cyc_i  in  1  master N cycle (N = 0,1; each mN_* port exists for both masters)
- mN_stb_i  in  1  master N strobe
- mN_adr_i  in  24  master N byte address
- mN_we_i  in  1  master N write enable
- mN_dat_i  in  8  master N write data
- mN_cti_i  in  3  master N cycle type, forwarded
- mN_bte_i  in  2  master N burst type, forwarded
- mN_ack_o  out  1  master N ack
- mN_err_o  out  1  master N error (slave err or watchdog)
- mN_rty_o  out  1  master N retry
- mN_dat_o  out  8  read data, driven from s_dat_i to both masters
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_adr_o  out  24  slave address
- s_we_o  out  1  slave write enable
- s_dat_o  out  8  slave write data
- s_cti_o  out  3  slave cycle type
- s_bte_o  out  2  slave burst type
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave error
- s_rty_i  in  1  slave retry
- s_dat_i  in  8  slave read data

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, last=1 (m0 wins first tie), wdog=0.
  - All s_* outputs 0; all mN_ack/err/rty 0.
- States: IDLE, OWN0, OWN1, ABORT. Registered `owner` follows the state (0 or 1).
- IDLE:
  - No slave outputs asserted.
  - Only m0_cyc_i high -> OWN0. Only m1_cyc_i high -> OWN1.
  - Both high -> grant the master != last.
  - The transition takes one cycle: request at edge N gives s_cyc_o at N+1.
- OWNx:
  - s_cyc_o = mx_cyc_i; s_stb_o = mx_cyc_i & mx_stb_i.
  - s_adr/we/dat/cti/bte are driven combinationally from master x.
  - mx_ack_o/err_o/rty_o = s_ack_i/s_err_i/s_rty_i gated by s_stb_o.
  - Non-owner ack/err/rty are held at 0.
  - On grant entry, last <= x.
  - mx_cyc_i low -> IDLE on the same edge. s_cyc_o is already low that cycle (combinational).
  - Re-arbitration happens in the following IDLE cycle, so there is a minimum 1 idle cycle between owners.
  - When slave is idle, slave outputs are don't-care but driven as 0.
- Watchdog:
  - wdog increments each cycle s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - Clears to 0 on ack, on err, on s_stb_o=0, and on leaving OWNx.
  - When TIMEOUT!=0 and wdog==TIMEOUT-1 with no ack that cycle: next state ABORT; wdog saturates, no wrap.
- ABORT (exactly 1 cycle):
  - s_cyc_o=s_stb_o=0. This resets the SPI controller, which deasserts chip-select.
  - owner's err_o=1 for this cycle; ack_o=0.
  - Then: owner cyc still high -> return to OWNx (owner keeps the bus); else IDLE.
- Simultaneous events:
  - s_ack_i on the same cycle the watchdog would fire: ack wins, no ABORT.
  - Owner drops cyc the same cycle as ack: ack still forwarded, then IDLE.
  - Non-owner requesting during OWNx is ignored until IDLE.
- Reset mid-transfer: all outputs drop immediately (async). The SPI controller sees cyc=0 and aborts.

Decomposition:
- Shared package `spi_pkg`:
  - arb_state_t enum {IDLE, OWN0, OWN1, ABORT}.
  - Wishbone CTI/BTE constants (CTI_CLASSIC=3'b000, CTI_INCREMENTING_BURST=3'b010, BTE_LINEAR=2'b00).
  - SPI address/data widths (24, 8).
- No sub-module. The watchdog is a counter inside the arbiter; it is not worth a separate module.

Test Plan:
- m0 read at 0x000123 alone, slave model acks after 82 cycles with 0xA5 -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o 1-cycle pulse with m0_dat_o=0xA5; m1_ack_o stays 0.
- m0 and m1 raise cyc on the same edge right after reset -> m0 granted first. After m0 drops cyc: 1 IDLE cycle, then m1 granted. Repeat the simultaneous request -> m1 then m0 alternate (round-robin).
- m1 owns the bus and issues 3 back-to-back stb with cyc held; m0 requests meanwhile -> m0 not granted until m1_cyc_i falls; all 3 m1 acks delivered.
- TIMEOUT=16, slave never acks -> s_stb_o high 16 cycles, then 1 cycle with s_cyc_o=0 and m0_err_o=1. With m0 cyc still high, the next cycle shows s_cyc_o=1 again.
- TIMEOUT=16, slave acks at cycle 16 exactly, the watchdog boundary -> ack forwarded, no err, no ABORT.
- Assert rst_i asynchronously mid-transfer (between clock edges) -> s_cyc_o, s_stb_o, and all acks go 0 immediately. After release the state is IDLE, and m0 wins the first tie.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI SRAM bus arbiter
package spi_pkg;

  localparam int SPI_AW = 24;
  localparam int SPI_DW = 8;

  localparam logic [2:0] CTI_CLASSIC            = 3'b000;
  localparam logic [2:0] CTI_INCREMENTING_BURST = 3'b010;
  localparam logic [1:0] BTE_LINEAR             = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - two-master round-robin Wishbone arbiter with watchdog for the SPI SRAM port
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic [SPI_AW-1:0] m0_adr_i,
  input  logic              m0_we_i,
  input  logic [SPI_DW-1:0] m0_dat_i,
  input  logic [2:0]        m0_cti_i,
  input  logic [1:0]        m0_bte_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,
  output logic [SPI_DW-1:0] m0_dat_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic [SPI_AW-1:0] m1_adr_i,
  input  logic              m1_we_i,
  input  logic [SPI_DW-1:0] m1_dat_i,
  input  logic [2:0]        m1_cti_i,
  input  logic [1:0]        m1_bte_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,
  output logic [SPI_DW-1:0] m1_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [SPI_AW-1:0] s_adr_o,
  output logic              s_we_o,
  output logic [SPI_DW-1:0] s_dat_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  input  logic [SPI_DW-1:0] s_dat_i
);

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WD_MAX  = '1;

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic          r_owner;
  logic          r_last;
  logic [TW-1:0] r_wdog;

  logic w_own;
  logic w_stb0;
  logic w_stb1;
  logic w_stalled;
  logic w_fire;

  assign w_own     = (r_state == OWN0) || (r_state == OWN1);
  assign w_stb0    = m0_cyc_i & m0_stb_i;
  assign w_stb1    = m1_cyc_i & m1_stb_i;
  assign w_stalled = s_stb_o & ~s_ack_i & ~s_err_i;
  assign w_fire    = (TIMEOUT != 0) && w_stalled && (r_wdog == WD_LAST);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // State register with owner and round-robin history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == OWN0) begin
        r_owner <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_next == OWN1) begin
        r_owner <= 1'b1;
        r_last  <= 1'b1;
      end
    end
  end

  // Watchdog counts stalled strobe cycles while the owner keeps the bus
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog <= '0;
    end else if (w_own && (w_next == r_state) && w_stalled) begin
      if (r_wdog != WD_MAX) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end else begin
      r_wdog <= '0;
    end
  end

  // Next-state: round-robin on ties, cyc-locked ownership, one-cycle abort
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = r_last ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          w_next = OWN0;
        end else if (m1_cyc_i) begin
          w_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          w_next = IDLE;
        end else if (w_fire) begin
          w_next = ABORT;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          w_next = IDLE;
        end else if (w_fire) begin
          w_next = ABORT;
        end
      end
      ABORT: begin
        if (r_owner) begin
          w_next = m1_cyc_i ? OWN1 : IDLE;
        end else begin
          w_next = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs: owner's request passes straight through, everything else held at 0
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_adr_o  = '0;
    s_we_o   = 1'b0;
    s_dat_o  = '0;
    s_cti_o  = CTI_CLASSIC;
    s_bte_o  = BTE_LINEAR;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (r_state)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = w_stb0;
        s_adr_o  = m0_adr_i;
        s_we_o   = m0_we_i;
        s_dat_o  = m0_dat_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i & w_stb0;
        m0_err_o = s_err_i & w_stb0;
        m0_rty_o = s_rty_i & w_stb0;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = w_stb1;
        s_adr_o  = m1_adr_i;
        s_we_o   = m1_we_i;
        s_dat_o  = m1_dat_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i & w_stb1;
        m1_err_o = s_err_i & w_stb1;
        m1_rty_o = s_rty_i & w_stb1;
      end
      ABORT: begin
        m0_err_o = ~r_owner;
        m1_err_o = r_owner;
      end
      default: begin
      end
    endcase
  end

endmodule
